// File: rtl/ram_pkg.sv
// Shared types, default widths and the write-priority helper for the multi-port clear RAM.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 8;
    localparam int CLR_WORDS_DEF = 32;

    // The helper works on port vectors padded to the largest supported configuration.
    localparam int MAX_PORTS  = 4;
    localparam int PORT_IDX_W = 2;
    localparam int ADDR_W_MAX = 16;

    typedef struct packed {
        logic                  hit;
        logic [PORT_IDX_W-1:0] idx;
    } win_t;

    // Highest-index enabled port whose address equals a; hit=0 when no port writes a.
    function automatic win_t win_port(
        input logic [MAX_PORTS-1:0]            en_v,
        input logic [MAX_PORTS*ADDR_W_MAX-1:0] addr_v,
        input logic [ADDR_W_MAX-1:0]           a
    );
        win_t w;
        w = '0;
        for (int p = 0; p < MAX_PORTS; p++) begin
            if (en_v[p] && (addr_v[p*ADDR_W_MAX +: ADDR_W_MAX] == a)) begin
                w.hit = 1'b1;
                w.idx = PORT_IDX_W'(p);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear engine: walks addresses 0..CLR_WORDS-1 writing zero, one word per cycle.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CLR_WORDS = CLR_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              last;

    assign last = (ptr_reg == ADDR_W'(CLR_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                if (start) begin
                    ptr_next = '0;
                end else if (last) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    // A restart on the final word aborts the run, so no completion pulse then.
    assign done     = busy && last && !start && !rst;
    assign clr_we   = busy;
    assign clr_addr = ptr_reg;

endmodule

// File: rtl/multi_port_ram_clr.sv
// N-port RAM with registered reads, highest-port-wins writes, collision flag and clear engine.
// Define MULTI_RAM_WR_BYPASS_EN to make reads write-first instead of read-first.
module multi_port_ram_clr
    import ram_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CLR_WORDS = CLR_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_PORTS-1:0]          en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   din,
    output logic [NUM_PORTS*DATA_W-1:0]   dout,
    output logic                          busy,
    output logic                          done,
    output logic                          collision
);

    localparam int DEPTH = 1 << ADDR_W;

    if (CLR_WORDS < 1 || CLR_WORDS > DEPTH) begin : g_bad_clr_words
        $error("CLR_WORDS must be in 1..2**ADDR_W");
    end
    if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
        $error("NUM_PORTS must be in 1..4");
    end
    if (ADDR_W < 1 || ADDR_W > ADDR_W_MAX) begin : g_bad_addr_w
        $error("ADDR_W must be in 1..16");
    end

    logic [DATA_W-1:0]               mem [DEPTH];
    logic                            clr_we;
    logic [ADDR_W-1:0]               clr_addr;
    logic                            idle;
    logic [ADDR_W-1:0]               port_addr [NUM_PORTS];
    logic [DATA_W-1:0]               port_din  [NUM_PORTS];
    logic [MAX_PORTS-1:0]            en_pad;
    logic [MAX_PORTS*ADDR_W_MAX-1:0] addr_pad;
    win_t                            win       [NUM_PORTS];
    logic [NUM_PORTS-1:0]            wr_win;
    logic [NUM_PORTS-1:0]            wr_ok;
    logic                            collision_reg;
    logic [DATA_W-1:0]               dout_reg  [NUM_PORTS];

    ram_clr_seq #(
        .ADDR_W    (ADDR_W),
        .CLR_WORDS (CLR_WORDS)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign idle = ~busy;

    always_comb begin
        en_pad   = '0;
        addr_pad = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            en_pad[p]                                = en[p];
            addr_pad[p*ADDR_W_MAX +: ADDR_W_MAX]     = ADDR_W_MAX'(addr[p*ADDR_W +: ADDR_W]);
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_addr[gi] = addr[gi*ADDR_W +: ADDR_W];
        assign port_din[gi]  = din[gi*DATA_W +: DATA_W];
        assign win[gi]       = win_port(en_pad, addr_pad, ADDR_W_MAX'(port_addr[gi]));
        // A port only writes if it is the top-priority writer of its own address.
        assign wr_win[gi]    = en[gi] && win[gi].hit && (win[gi].idx == PORT_IDX_W'(gi));
        assign wr_ok[gi]     = idle && wr_win[gi];
        assign dout[gi*DATA_W +: DATA_W] = dout_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_ok[p]) begin
                    mem[port_addr[p]] <= port_din[p];
                end
            end
        end
    end

    // Any enabled port that lost priority implies a same-address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= idle && |(en & ~wr_win);
        end
    end

    assign collision = collision_reg;

`ifdef MULTI_RAM_WR_BYPASS_EN
    logic [DATA_W-1:0] din_all [MAX_PORTS];

    always_comb begin
        for (int p = 0; p < MAX_PORTS; p++) begin
            din_all[p] = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            din_all[p] = port_din[p];
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rd
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_reg[gi] <= '0;
            end else if (busy) begin
                dout_reg[gi] <= '0;
            end else if (win[gi].hit) begin
                dout_reg[gi] <= din_all[win[gi].idx];
            end else begin
                dout_reg[gi] <= mem[port_addr[gi]];
            end
        end
    end
`else
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rd
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_reg[gi] <= '0;
            end else if (busy) begin
                dout_reg[gi] <= '0;
            end else begin
                dout_reg[gi] <= mem[port_addr[gi]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_port_ram_clr.sv
// Directed bench for multi_port_ram_clr with two 32-bit ports and a 32-word clear region.
module tb_multi_port_ram_clr;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [NP-1:0]     en;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  din;
    logic [NP*DW-1:0]  dout;
    logic              busy;
    logic              done;
    logic              collision;

    int total = 0;
    int bad   = 0;

    multi_port_ram_clr #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .CLR_WORDS (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (en),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .busy      (busy),
        .done      (done),
        .collision (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left at a falling edge; inputs change only there.
    task automatic wr(input int p, input logic [7:0] a, input logic [31:0] d);
        en = '0;
        en[p] = 1'b1;
        addr[p*AW +: AW] = a;
        din[p*DW +: DW] = d;
        @(negedge clk);
        en = '0;
        $display("wr p%0d a=%h d=%h", p, a, d);
    endtask

    task automatic rd(input int p, input logic [7:0] a, output logic [31:0] d);
        en = '0;
        addr[p*AW +: AW] = a;
        @(negedge clk);
        d = dout[p*DW +: DW];
        $display("rd p%0d a=%h d=%h", p, a, d);
    endtask

    // Observes one clear run starting at the current falling edge (first busy cycle).
    task automatic watch_clear(input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int coll_cnt = 0;
        int dnz_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (collision) coll_cnt++;
            if (dout != '0) dnz_cnt++;
            @(negedge clk);
        end
        $display("clear %s busy_cycles=%0d done_at=%0d", tag, busy_cnt, done_at);
        chk({tag, "_busy_cycles"}, busy_cnt, 32);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_at"}, done_at, 31);
        chk({tag, "_coll_in_clear"}, coll_cnt, 0);
        chk({tag, "_dout_in_clear"}, dnz_cnt, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    logic [31:0] d;
    int          zero_bad;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        en    = '0;
        addr  = '0;
        din   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_coll", collision, 0);
        chk("rst_dout", dout[31:0] | dout[63:32], 0);

        // 1: automatic clear after reset release
        rst = 1'b0;
        watch_clear("t1");
        zero_bad = 0;
        for (int a = 0; a < 32; a++) begin
            rd(a % 2, 8'(a), d);
            if (d !== 32'h0) zero_bad++;
        end
        chk("t1_zero_reads", zero_bad, 0);

        // 2: simple write then cross-port read
        wr(0, 8'h05, 32'hDEADBEEF);
        chk("t2_no_coll", collision, 0);
        rd(1, 8'h05, d);
        chk("t2_rd05", d, 32'hDEADBEEF);

        // 3: same-address collision, highest port wins
        en = 2'b11;
        addr = {8'h10, 8'h10};
        din = {32'h22222222, 32'h11111111};
        @(negedge clk);
        en = '0;
        $display("wr both a=10 collision=%b", collision);
        chk("t3_coll_pulse", collision, 1);
        @(negedge clk);
        chk("t3_coll_clear", collision, 0);
        rd(0, 8'h10, d);
        chk("t3_rd10", d, 32'h22222222);
        en = 2'b11;
        addr = {8'h41, 8'h40};
        din = {32'h00000041, 32'h00000040};
        @(negedge clk);
        en = '0;
        @(negedge clk);
        chk("t3_no_coll_diff", collision, 0);
        rd(1, 8'h40, d);
        chk("t3_rd40", d, 32'h00000040);

        // 4: read of an address written in the same cycle
        wr(0, 8'h20, 32'h0);
        en = 2'b01;
        addr = {8'h20, 8'h20};
        din[31:0] = 32'hA5A5A5A5;
        @(negedge clk);
        en = '0;
        d = dout[63:32];
        $display("rd p1 a=20 same-cycle d=%h", d);
`ifdef MULTI_RAM_WR_BYPASS_EN
        chk("t4_same_cycle", d, 32'hA5A5A5A5);
`else
        chk("t4_same_cycle", d, 32'h0);
`endif
        rd(1, 8'h20, d);
        chk("t4_after", d, 32'hA5A5A5A5);

        // 5: restart mid-clear; writes while busy are dropped
        wr(0, 8'h03, 32'h00001234);
        rd(0, 8'h03, d);
        chk("t5_pre", d, 32'h00001234);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en = 2'b11;
        addr = {8'h03, 8'h03};
        din = {32'h0000BAD1, 32'h0000BAD0};
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch_clear("t5");
        en = '0;
        rd(0, 8'h03, d);
        chk("t5_rd03", d, 32'h0);
        rd(1, 8'h05, d);
        chk("t5_rd05", d, 32'h0);
        rd(0, 8'h40, d);
        chk("t5_rd40_kept", d, 32'h00000040);

        // 6: reset in the middle of a clear
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en = 2'b11;
        addr = {8'h07, 8'h07};
        din = {32'h77777777, 32'h66666666};
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_dout", dout[31:0] | dout[63:32], 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_coll", collision, 0);
        chk("t6_rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        watch_clear("t6");
        en = '0;
        rd(1, 8'h07, d);
        chk("t6_rd07", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
